// File: rtl/tick_timer.sv
// Programmable interval timer: counts down selected tick strobes from a reload
// value, with one-shot/periodic expiry, a sticky IRQ and an overrun flag.
module tick_timer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK_5MHZ,
  input  logic             TICK_1MHZ,
  input  logic             TICK_1KHZ,
  input  logic             TICK_1HZ,
  input  logic [1:0]       SEL,
  input  logic             MODE,
  input  logic [CNT_W-1:0] RELOAD,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOAD,
  input  logic             IRQ_ACK,
  output logic [CNT_W-1:0] COUNT,
  output logic             RUNNING,
  output logic             IRQ,
  output logic             OVERRUN,
  output logic             EXPIRE_TICK
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Decrement that floors at zero instead of wrapping.
  function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             expire_q, expire_d;
  logic [3:0]       ticks;
  logic             tsel;

  assign ticks = {TICK_1HZ, TICK_1KHZ, TICK_1MHZ, TICK_5MHZ};
  assign tsel  = ticks[SEL];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    irq_d    = irq_q;
    ovr_d    = ovr_q;
    expire_d = 1'b0;

    if (IRQ_ACK) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end

    if (STOP) begin
      state_d = IDLE;
    end else if (START) begin
      count_d = RELOAD;
      state_d = RUN;
    end else if (LOAD) begin
      count_d = RELOAD;
    end else if (state_q == RUN && tsel) begin
      if (count_q > ONE) begin
        count_d = dec_floor(count_q);
      end else begin
        // Expiry: a simultaneous ack lets the new IRQ stand without flagging overrun.
        expire_d = 1'b1;
        irq_d    = 1'b1;
        if (irq_q && !IRQ_ACK) ovr_d = 1'b1;
        if (MODE) begin
          count_d = RELOAD;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      count_q  <= '0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
      expire_q <= expire_d;
    end
  end

  assign COUNT       = count_q;
  assign RUNNING     = (state_q == RUN);
  assign IRQ         = irq_q;
  assign OVERRUN     = ovr_q;
  assign EXPIRE_TICK = expire_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the countdown/interrupt rules.
module tb_tick_timer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        TICK_5MHZ = 1'b0, TICK_1MHZ = 1'b0, TICK_1KHZ = 1'b0, TICK_1HZ = 1'b0;
  logic [1:0]  SEL = 2'd0;
  logic        MODE = 1'b0;
  logic [15:0] RELOAD = 16'd0;
  logic        START = 1'b0, STOP = 1'b0, LOAD = 1'b0, IRQ_ACK = 1'b0;
  logic [15:0] COUNT;
  logic        RUNNING, IRQ, OVERRUN, EXPIRE_TICK;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model state
  int m_count = 0;
  bit m_run = 0, m_irq = 0, m_ovr = 0, m_exp = 0;

  tick_timer #(.CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .TICK_5MHZ(TICK_5MHZ), .TICK_1MHZ(TICK_1MHZ), .TICK_1KHZ(TICK_1KHZ), .TICK_1HZ(TICK_1HZ),
    .SEL(SEL), .MODE(MODE), .RELOAD(RELOAD),
    .START(START), .STOP(STOP), .LOAD(LOAD), .IRQ_ACK(IRQ_ACK),
    .COUNT(COUNT), .RUNNING(RUNNING), .IRQ(IRQ), .OVERRUN(OVERRUN), .EXPIRE_TICK(EXPIRE_TICK)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_update();
    logic [3:0] tv;
    bit tk;
    bit irq_was;
    tv = {TICK_1HZ, TICK_1KHZ, TICK_1MHZ, TICK_5MHZ};
    tk = tv[SEL];
    irq_was = m_irq;
    m_exp = 0;
    if (RESET) begin
      m_count = 0; m_run = 0; m_irq = 0; m_ovr = 0;
      return;
    end
    if (IRQ_ACK) begin m_irq = 0; m_ovr = 0; end
    if (STOP) m_run = 0;
    else if (START) begin m_count = int'(RELOAD); m_run = 1; end
    else if (LOAD) m_count = int'(RELOAD);
    else if (m_run && tk) begin
      if (m_count > 1) m_count = m_count - 1;
      else begin
        m_exp = 1;
        if (irq_was && !IRQ_ACK) m_ovr = 1;
        m_irq = 1;
        if (MODE) m_count = int'(RELOAD);
        else begin m_count = 0; m_run = 0; end
      end
    end
  endtask

  // One clock: update the model with the applied inputs, clock, compare, drop strobes.
  task automatic step();
    model_update();
    @(posedge CLK); #1;
    check("count",   32'(COUNT),       32'(m_count));
    check("running", 32'(RUNNING),     32'(m_run));
    check("irq",     32'(IRQ),         32'(m_irq));
    check("overrun", 32'(OVERRUN),     32'(m_ovr));
    check("expire",  32'(EXPIRE_TICK), 32'(m_exp));
    {TICK_5MHZ, TICK_1MHZ, TICK_1KHZ, TICK_1HZ} = 4'b0;
    {START, STOP, LOAD, IRQ_ACK, RESET} = 5'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    RESET = 1; step();
    check("rst_count", 32'(COUNT), 0);
    check("rst_running", 32'(RUNNING), 0);
    check("rst_irq", 32'(IRQ), 0);
    check("rst_expire", 32'(EXPIRE_TICK), 0);

    // One-shot, 1 kHz ticks 10 clocks apart
    SEL = 2'd2; RELOAD = 16'd3; MODE = 0; START = 1; step();
    check("os_load", 32'(COUNT), 3);
    for (int t = 1; t <= 4; t++) begin
      TICK_1KHZ = 1; step();
      if (t < 3) check("os_count", 32'(COUNT), 32'(3 - t));
      if (t == 3) begin
        check("os_expire", 32'(EXPIRE_TICK), 1);
        check("os_zero", 32'(COUNT), 0);
        check("os_irq", 32'(IRQ), 1);
        check("os_done", 32'(RUNNING), 0);
      end
      if (t == 4) check("os_after", 32'(EXPIRE_TICK), 0);
      idle(9);
    end

    // Periodic with overrun, then ack
    MODE = 1; RELOAD = 16'd2; SEL = 2'd1; IRQ_ACK = 1; START = 1; step();
    for (int t = 1; t <= 6; t++) begin
      TICK_1MHZ = 1; step();
      check("per_expire", 32'(EXPIRE_TICK), 32'(t % 2 == 0));
      if (t % 2 == 0) check("per_reload", 32'(COUNT), 2);
      if (t == 4) check("per_ovr", 32'(OVERRUN), 1);
      idle(2);
    end
    IRQ_ACK = 1; step();
    check("ack_irq", 32'(IRQ), 0);
    check("ack_ovr", 32'(OVERRUN), 0);

    // Expiry with ack in the same cycle while IRQ pending
    RELOAD = 16'd1; START = 1; step();
    TICK_1MHZ = 1; step();
    check("pre_irq", 32'(IRQ), 1);
    TICK_1MHZ = 1; IRQ_ACK = 1; step();
    check("sim_irq", 32'(IRQ), 1);
    check("sim_ovr", 32'(OVERRUN), 0);

    // STOP beats a tick
    RELOAD = 16'd5; START = 1; step();
    STOP = 1; TICK_1MHZ = 1; step();
    check("stop_count", 32'(COUNT), 5);
    check("stop_run", 32'(RUNNING), 0);

    // START beats a tick
    RELOAD = 16'd4; START = 1; TICK_1MHZ = 1; step();
    check("start_count", 32'(COUNT), 4);

    // SEL filtering
    MODE = 0; SEL = 2'd3; RELOAD = 16'd1; START = 1; step();
    for (int i = 0; i < 100; i++) begin
      TICK_5MHZ = 1; TICK_1MHZ = 1; TICK_1KHZ = 1; step();
    end
    check("sel_count", 32'(COUNT), 1);
    TICK_1HZ = 1; step();
    check("sel_expire", 32'(EXPIRE_TICK), 1);

    // RELOAD = 0 expires on first tick
    SEL = 2'd0; RELOAD = 16'd0; START = 1; step();
    TICK_5MHZ = 1; step();
    check("r0_expire", 32'(EXPIRE_TICK), 1);
    check("r0_count", 32'(COUNT), 0);

    // Full-width reload
    RELOAD = 16'hFFFF; START = 1; step();
    for (int i = 1; i <= 65535; i++) begin
      TICK_5MHZ = 1; step();
      if (i == 65534) check("max_noexp", 32'(EXPIRE_TICK), 0);
    end
    check("max_expire", 32'(EXPIRE_TICK), 1);

    // Reset mid-count with IRQ pending
    MODE = 1; RELOAD = 16'd1; START = 1; step();
    TICK_5MHZ = 1; step();
    RELOAD = 16'd9; LOAD = 1; step();
    TICK_5MHZ = 1; step();
    TICK_5MHZ = 1; step();
    check("mid_count", 32'(COUNT), 7);
    RESET = 1; TICK_5MHZ = 1; step();
    check("mr_count", 32'(COUNT), 0);
    check("mr_irq", 32'(IRQ), 0);
    check("mr_running", 32'(RUNNING), 0);
    TICK_5MHZ = 1; step();
    check("mr_ignore", 32'(COUNT), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(49) == 0) SEL = 2'($urandom_range(3));
      if ($urandom_range(49) == 0) MODE = 1'($urandom_range(1));
      if ($urandom_range(29) == 0) RELOAD = 16'($urandom_range(6));
      TICK_5MHZ = ($urandom_range(2) == 0);
      TICK_1MHZ = ($urandom_range(2) == 0);
      TICK_1KHZ = ($urandom_range(2) == 0);
      TICK_1HZ  = ($urandom_range(2) == 0);
      START   = ($urandom_range(31) == 0);
      STOP    = ($urandom_range(63) == 0);
      LOAD    = ($urandom_range(63) == 0);
      IRQ_ACK = ($urandom_range(15) == 0);
      RESET   = ($urandom_range(299) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
